// File: rtl/int_priority_ctrl_pkg.sv
// Shared types and helpers for the three-source priority interrupt controller.
package int_pkg;

    localparam int NUM_SRC = 3;
    localparam int ADDR_W  = 12;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Source number 1..3; 0 means "no source" (also the lowest priority level).
    typedef logic [1:0] src_t;

    // Highest-numbered set bit as a source number, 0 when no bit is set.
    function automatic src_t highest_set(input logic [NUM_SRC-1:0] bits);
        src_t r;
        r = 2'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bits[i]) r = src_t'(i + 1);
        end
        return r;
    endfunction

    // One-hot mask of a source number; all zeros for source 0.
    function automatic logic [NUM_SRC-1:0] src_onehot(input src_t s);
        logic [NUM_SRC-1:0] r;
        for (int i = 0; i < NUM_SRC; i++) begin
            r[i] = (s == src_t'(i + 1));
        end
        return r;
    endfunction

endpackage

// File: rtl/int_priority_ctrl_if.sv
// CPU-side bundle of the interrupt controller.
// Handshake: while interrupt is high the offer (isr_addr) is stable; the CPU
// takes it by holding ack high for one clock edge, after which interrupt is
// low for at least one cycle. ack while interrupt is low is ignored. eret
// (one edge) ends the highest-priority ISR currently in service.
interface int_priority_ctrl_if;
    import int_pkg::*;

    logic              break1;
    logic              break2;
    logic              break3;
    logic              en_we;
    logic [2:0]        en_wdata;
    logic              ack;
    logic              eret;
    logic              interrupt;
    logic [ADDR_W-1:0] isr_addr;
    logic              IW1;
    logic              IW2;
    logic              IW3;
    logic              ir1_sig;
    logic              ir2_sig;
    logic              ir3_sig;

    modport master (
        output break1, break2, break3, en_we, en_wdata, ack, eret,
        input  interrupt, isr_addr, IW1, IW2, IW3, ir1_sig, ir2_sig, ir3_sig
    );

    modport slave (
        input  break1, break2, break3, en_we, en_wdata, ack, eret,
        output interrupt, isr_addr, IW1, IW2, IW3, ir1_sig, ir2_sig, ir3_sig
    );
endinterface

// File: rtl/int_priority_ctrl_irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous request line followed by a
// third flop; emits a one-cycle pulse for each synchronized rising edge.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic pulse_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus edge-history flop, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;
endmodule

// File: rtl/int_priority_ctrl.sv
// Three-source nested priority interrupt controller: pending/in-service
// tracking, enable mask, and a two-state offer FSM (IDLE/REQ).
module int_priority_ctrl
    import int_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ISR1_ADDR = 12'h010,
    parameter logic [ADDR_W-1:0] ISR2_ADDR = 12'h020,
    parameter logic [ADDR_W-1:0] ISR3_ADDR = 12'h030
) (
    input  logic                clk,
    input  logic                RST,
    int_priority_ctrl_if.slave  bus,
    output state_t              dbg_state_o
);
    logic [NUM_SRC-1:0] brk;
    logic [NUM_SRC-1:0] rise;

    state_t             state_q, state_d;
    src_t               src_q, src_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] isr_q, isr_d;
    logic [NUM_SRC-1:0] en_q, en_d;

    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] src_oh;
    src_t               hi_srv;
    src_t               best;
    logic               withdraw;

    assign brk = {bus.break3, bus.break2, bus.break1};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk     (clk),
            .rst     (RST),
            .async_i (brk[g]),
            .pulse_o (rise[g])
        );
    end

    // State, latched source, pending, in-service and enable registers.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            src_q   <= 2'd0;
            pend_q  <= '0;
            isr_q   <= '0;
            en_q    <= '1;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
            en_q    <= en_d;
        end
    end

    // Arbitration, offer FSM and pending/in-service bookkeeping.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        pend_d  = pend_q;
        isr_d   = isr_q;
        en_d    = bus.en_we ? bus.en_wdata : en_q;

        hi_srv = highest_set(isr_q);
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = pend_q[i] & en_q[i] & (src_t'(i + 1) > hi_srv);
        end
        best   = highest_set(elig);
        src_oh = src_onehot(src_q);
        // The offered source lost its enable, either already or by this write.
        withdraw = ((src_oh & en_q) == '0) ||
                   (bus.en_we && ((src_oh & bus.en_wdata) == '0));

        case (state_q)
            IDLE: begin
                if (best != 2'd0) begin
                    state_d = REQ;
                    src_d   = best;
                end
            end
            REQ: begin
                if (bus.ack || withdraw) begin
                    state_d = IDLE;
                    src_d   = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
                src_d   = 2'd0;
            end
        endcase

        // eret retires the innermost ISR before a same-cycle ack is applied.
        if (bus.eret) begin
            isr_d = isr_d & ~src_onehot(hi_srv);
        end
        if (state_q == REQ && bus.ack) begin
            pend_d = pend_d & ~src_oh;
            isr_d  = isr_d | src_oh;
        end
        // A fresh edge wins over a same-cycle clear so the request is not lost.
        pend_d = pend_d | rise;
    end

    // Offer outputs decoded from the registered state and latched source.
    always_comb begin
        bus.isr_addr = '0;
        if (state_q == REQ) begin
            case (src_q)
                2'd1:    bus.isr_addr = ISR1_ADDR;
                2'd2:    bus.isr_addr = ISR2_ADDR;
                2'd3:    bus.isr_addr = ISR3_ADDR;
                default: bus.isr_addr = '0;
            endcase
        end
    end

    assign bus.interrupt = (state_q == REQ);
    assign bus.IW1       = pend_q[0];
    assign bus.IW2       = pend_q[1];
    assign bus.IW3       = pend_q[2];
    assign bus.ir1_sig   = isr_q[0];
    assign bus.ir2_sig   = isr_q[1];
    assign bus.ir3_sig   = isr_q[2];
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_int_priority_ctrl.sv
// Bench for int_priority_ctrl: directed scenarios with literal expectations
// plus a per-cycle comparison against a behavioural model of the controller.
module tb_int_priority_ctrl;
  import int_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic RST;
  logic chk_en;
  state_t dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int_priority_ctrl_if bus();

  int_priority_ctrl dut (
    .clk         (clk),
    .RST         (RST),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- behavioural model ----------------
  // Sources numbered 1..3; priority equals the number. h1/h2/h3 hold the
  // break levels seen at the last three clock edges.
  typedef struct packed {
    logic [2:0] pend;
    logic [2:0] isr;
    logic [2:0] en;
    logic [1:0] offer;
    logic [2:0] h1;
    logic [2:0] h2;
    logic [2:0] h3;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t c, input logic rst,
                                        input logic [2:0] brk, input logic we,
                                        input logic [2:0] wd, input logic ack,
                                        input logic eret);
    model_t n;
    int hi;
    int best;
    int o;
    if (rst) begin
      n = '0;
      n.en = 3'b111;
      return n;
    end
    n = c;
    hi = 0;
    for (int i = 1; i <= 3; i++) if (c.isr[i-1]) hi = i;
    o = int'(c.offer);
    if (o == 0) begin
      best = 0;
      for (int i = 1; i <= 3; i++)
        if (c.pend[i-1] && c.en[i-1] && i > hi) best = i;
      n.offer = 2'(best);
    end else if (ack) begin
      n.offer = 2'd0;
    end else if (!c.en[o-1] || (we && !wd[o-1])) begin
      n.offer = 2'd0;
    end
    if (eret && hi != 0) n.isr[hi-1] = 1'b0;
    if (o != 0 && ack) begin
      n.pend[o-1] = 1'b0;
      n.isr[o-1]  = 1'b1;
    end
    n.pend = n.pend | (c.h2 & ~c.h3);
    if (we) n.en = wd;
    n.h3 = c.h2;
    n.h2 = c.h1;
    n.h1 = brk;
    return n;
  endfunction

  always @(posedge clk)
    m <= model_step(m, RST, {bus.break3, bus.break2, bus.break1}, bus.en_we,
                    bus.en_wdata, bus.ack, bus.eret);

  function automatic logic [18:0] model_vec();
    return {m.offer != 2'd0, 6'd0, m.offer, 4'd0, m.pend, m.isr};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {bus.interrupt, bus.isr_addr, bus.IW3, bus.IW2, bus.IW1,
            bus.ir3_sig, bus.ir2_sig, bus.ir1_sig};
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle; outputs compared to the model on the falling edge.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) check("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic [2:0] mask);
    {bus.break3, bus.break2, bus.break1} = mask;
    cyc();
    {bus.break3, bus.break2, bus.break1} = 3'b000;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    cyc();
    bus.eret = 1'b0;
  endtask

  task automatic wait_offer(input string name, input logic [11:0] addr);
    int n;
    n = 0;
    while (!bus.interrupt && n < 10) begin
      cyc();
      n++;
    end
    check(name, 32'({bus.interrupt, bus.isr_addr}), 32'({1'b1, addr}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_en = 1'b0;
    RST = 1'b1;
    bus.break1 = 1'b0; bus.break2 = 1'b0; bus.break3 = 1'b0;
    bus.en_we = 1'b0; bus.en_wdata = 3'b111; bus.ack = 1'b0; bus.eret = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    cyc(); cyc();
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    RST = 1'b0;
    cyc(); cyc();

    // Single source 1: pending at k+2, offer at k+3, ack three cycles later.
    bus.break1 = 1'b1; cyc();
    bus.break1 = 1'b0; cyc();
    check("iw1_k1", 32'(bus.IW1), 32'd0);
    cyc();
    check("iw1_k2", 32'({bus.interrupt, bus.IW1}), 32'b01);
    cyc();
    check("offer_k3", 32'({bus.interrupt, bus.isr_addr}), 32'({1'b1, 12'h010}));
    cyc(); cyc();
    do_ack();
    check("ack_src1", 32'({bus.interrupt, bus.isr_addr, bus.IW1, bus.ir1_sig}), 32'b01);
    do_eret();
    check("eret_src1", 32'(bus.ir1_sig), 32'd0);
    do_ack();
    check("ack_idle", 32'(dut_vec()), 32'd0);

    // All three at once: served 3, 2, 1.
    pulse(3'b111);
    wait_offer("all_first", 12'h030);
    do_ack();
    check("all_state", 32'({bus.ir3_sig, bus.ir2_sig, bus.ir1_sig, bus.IW3, bus.IW2, bus.IW1}),
          32'b100011);
    cyc(); cyc();
    check("all_blocked", 32'(bus.interrupt), 32'd0);
    do_eret();
    wait_offer("all_second", 12'h020);
    do_ack(); do_eret();
    wait_offer("all_third", 12'h010);
    do_ack(); do_eret();

    // Nesting: source 3 preempts source 1.
    pulse(3'b001);
    wait_offer("nest_low", 12'h010);
    do_ack();
    pulse(3'b100);
    wait_offer("nest_high", 12'h030);
    do_ack();
    check("nest_both", 32'({bus.ir3_sig, bus.ir1_sig}), 32'b11);
    do_eret();
    check("nest_eret", 32'({bus.ir3_sig, bus.ir1_sig}), 32'b01);
    do_eret();

    // Lower priority waits for eret, then is offered the next cycle.
    pulse(3'b100);
    wait_offer("block_high", 12'h030);
    do_ack();
    pulse(3'b010);
    repeat (5) cyc();
    check("block_wait", 32'({bus.interrupt, bus.IW2}), 32'b01);
    do_eret();
    check("block_eret", 32'(bus.interrupt), 32'd0);
    cyc();
    check("block_offer", 32'({bus.interrupt, bus.isr_addr}), 32'({1'b1, 12'h020}));
    do_ack(); do_eret();

    // Withdrawal by disabling, re-offer after re-enabling.
    pulse(3'b010);
    wait_offer("wd_offer", 12'h020);
    bus.en_we = 1'b1; bus.en_wdata = 3'b101; cyc(); bus.en_we = 1'b0;
    check("wd_drop", 32'({bus.interrupt, bus.IW2}), 32'b01);
    cyc(); cyc();
    check("wd_hold", 32'({bus.interrupt, bus.IW2}), 32'b01);
    bus.en_we = 1'b1; bus.en_wdata = 3'b111; cyc(); bus.en_we = 1'b0;
    check("wd_enable", 32'(bus.interrupt), 32'd0);
    cyc();
    check("wd_reoffer", 32'({bus.interrupt, bus.isr_addr}), 32'({1'b1, 12'h020}));
    do_ack(); do_eret();

    // New edge landing on the ack cycle keeps the source pending.
    pulse(3'b001);
    wait_offer("merge_offer", 12'h010);
    bus.break1 = 1'b1; cyc();
    bus.break1 = 1'b0; cyc();
    do_ack();
    check("merge_pend", 32'({bus.IW1, bus.ir1_sig}), 32'b11);
    do_eret();
    wait_offer("merge_again", 12'h010);
    do_ack(); do_eret();

    // eret and ack together: eret retires source 1, ack enters source 3.
    pulse(3'b001);
    wait_offer("both_low", 12'h010);
    do_ack();
    pulse(3'b100);
    wait_offer("both_high", 12'h030);
    bus.eret = 1'b1; bus.ack = 1'b1; cyc(); bus.eret = 1'b0; bus.ack = 1'b0;
    check("both_isr", 32'({bus.ir3_sig, bus.ir2_sig, bus.ir1_sig}), 32'b100);
    do_eret();

    // Reset in REQ with two ISRs in service, break1 held through release.
    pulse(3'b001);
    wait_offer("rst_s1", 12'h010);
    do_ack();
    pulse(3'b010);
    wait_offer("rst_s2", 12'h020);
    do_ack();
    pulse(3'b100);
    wait_offer("rst_s3", 12'h030);
    RST = 1'b1; bus.break1 = 1'b1; cyc();
    check("rst_mid_req", 32'(dut_vec()), 32'd0);
    cyc();
    RST = 1'b0;
    cyc(); cyc();
    check("rst_iw1_early", 32'(bus.IW1), 32'd0);
    cyc();
    check("rst_iw1_set", 32'({bus.interrupt, bus.IW1}), 32'b01);
    wait_offer("rst_offer", 12'h010);
    do_ack();
    repeat (4) cyc();
    check("rst_single_edge", 32'({bus.interrupt, bus.IW1, bus.ir1_sig}), 32'b001);
    bus.break1 = 1'b0;
    do_eret();
    cyc();
    check("final_idle", 32'(dut_vec()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
